// File: rtl/axi_lite_arb_pkg.sv
// Shared types and response codes for the 2:1 AXI4-Lite arbiter.
package axi_lite_arb_pkg;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_ADDR = 2'd1,
    WR_RESP = 2'd2
  } wr_arb_state_t;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_RESP = 2'd2
  } rd_arb_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_rr_arb2.sv
// Two-requester round-robin grant; `last` names the port that owned the previous grant.
module axi_lite_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       enable,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/axi_4_lite_arbiter_2to1.sv
// Two-master to one-slave AXI4-Lite arbiter: independent round-robin write and read paths,
// registered grant, combinational payload/handshake forwarding while a grant is held.
module axi_4_lite_arbiter_2to1
  import axi_lite_arb_pkg::*;
#(
  parameter int ADDRESS    = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [ADDRESS-1:0]      S0_AWADDR,
  input  logic                    S0_AWVALID,
  output logic                    S0_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S0_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S0_WSTRB,
  input  logic                    S0_WVALID,
  output logic                    S0_WREADY,
  output logic [1:0]              S0_BRESP,
  output logic                    S0_BVALID,
  input  logic                    S0_BREADY,
  input  logic [ADDRESS-1:0]      S0_ARADDR,
  input  logic                    S0_ARVALID,
  output logic                    S0_ARREADY,
  output logic [DATA_WIDTH-1:0]   S0_RDATA,
  output logic [1:0]              S0_RRESP,
  output logic                    S0_RVALID,
  input  logic                    S0_RREADY,
  input  logic [ADDRESS-1:0]      S1_AWADDR,
  input  logic                    S1_AWVALID,
  output logic                    S1_AWREADY,
  input  logic [DATA_WIDTH-1:0]   S1_WDATA,
  input  logic [DATA_WIDTH/8-1:0] S1_WSTRB,
  input  logic                    S1_WVALID,
  output logic                    S1_WREADY,
  output logic [1:0]              S1_BRESP,
  output logic                    S1_BVALID,
  input  logic                    S1_BREADY,
  input  logic [ADDRESS-1:0]      S1_ARADDR,
  input  logic                    S1_ARVALID,
  output logic                    S1_ARREADY,
  output logic [DATA_WIDTH-1:0]   S1_RDATA,
  output logic [1:0]              S1_RRESP,
  output logic                    S1_RVALID,
  input  logic                    S1_RREADY,
  output logic [ADDRESS-1:0]      M_AWADDR,
  output logic                    M_AWVALID,
  input  logic                    M_AWREADY,
  output logic [DATA_WIDTH-1:0]   M_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_WSTRB,
  output logic                    M_WVALID,
  input  logic                    M_WREADY,
  input  logic [1:0]              M_BRESP,
  input  logic                    M_BVALID,
  output logic                    M_BREADY,
  output logic [ADDRESS-1:0]      M_ARADDR,
  output logic                    M_ARVALID,
  input  logic                    M_ARREADY,
  input  logic [DATA_WIDTH-1:0]   M_RDATA,
  input  logic [1:0]              M_RRESP,
  input  logic                    M_RVALID,
  output logic                    M_RREADY,
  output logic [1:0]              WR_GRANT,
  output logic [1:0]              RD_GRANT
);

  wr_arb_state_t wr_state_q;
  rd_arb_state_t rd_state_q;
  logic [1:0]    wr_grant_q, wr_grant_d, rd_grant_q, rd_grant_d;
  logic          last_wr_q, last_rd_q, aw_done_q, w_done_q;

  axi_lite_rr_arb2 u_wr_arb (
    .req    ({S1_AWVALID, S0_AWVALID}),
    .last   (last_wr_q),
    .enable (wr_state_q == WR_IDLE),
    .grant  (wr_grant_d)
  );

  axi_lite_rr_arb2 u_rd_arb (
    .req    ({S1_ARVALID, S0_ARVALID}),
    .last   (last_rd_q),
    .enable (rd_state_q == RD_IDLE),
    .grant  (rd_grant_d)
  );

  logic wr_sel, wr_act, wr_addr_ph, wr_resp_ph, aw_hs, w_hs, b_hs, aw_rdy, w_rdy, b_vld;
  assign wr_sel     = wr_grant_q[1];
  assign wr_act     = (wr_state_q != WR_IDLE);
  assign wr_addr_ph = (wr_state_q == WR_ADDR);
  assign wr_resp_ph = (wr_state_q == WR_RESP);

  // Write path: payload only while a grant is held, handshakes gated by the done flags.
  assign M_AWADDR  = !wr_act ? '0 : (wr_sel ? S1_AWADDR : S0_AWADDR);
  assign M_WDATA   = !wr_act ? '0 : (wr_sel ? S1_WDATA  : S0_WDATA);
  assign M_WSTRB   = !wr_act ? '0 : (wr_sel ? S1_WSTRB  : S0_WSTRB);
  assign M_AWVALID = wr_addr_ph & !aw_done_q & (wr_sel ? S1_AWVALID : S0_AWVALID);
  assign M_WVALID  = wr_addr_ph & !w_done_q  & (wr_sel ? S1_WVALID  : S0_WVALID);
  assign M_BREADY  = wr_resp_ph & (wr_sel ? S1_BREADY : S0_BREADY);

  assign aw_rdy = wr_addr_ph & !aw_done_q & M_AWREADY;
  assign w_rdy  = wr_addr_ph & !w_done_q  & M_WREADY;
  assign b_vld  = wr_resp_ph & M_BVALID;
  assign S0_AWREADY = aw_rdy & wr_grant_q[0];
  assign S1_AWREADY = aw_rdy & wr_grant_q[1];
  assign S0_WREADY  = w_rdy  & wr_grant_q[0];
  assign S1_WREADY  = w_rdy  & wr_grant_q[1];
  assign S0_BVALID  = b_vld  & wr_grant_q[0];
  assign S1_BVALID  = b_vld  & wr_grant_q[1];
  assign S0_BRESP   = (b_vld & wr_grant_q[0]) ? M_BRESP : RESP_OKAY;
  assign S1_BRESP   = (b_vld & wr_grant_q[1]) ? M_BRESP : RESP_OKAY;

  assign aw_hs = M_AWVALID & M_AWREADY;
  assign w_hs  = M_WVALID & M_WREADY;
  assign b_hs  = M_BVALID & M_BREADY;

  logic rd_sel, rd_act, rd_addr_ph, rd_resp_ph, ar_hs, r_hs, r_vld;
  assign rd_sel     = rd_grant_q[1];
  assign rd_act     = (rd_state_q != RD_IDLE);
  assign rd_addr_ph = (rd_state_q == RD_ADDR);
  assign rd_resp_ph = (rd_state_q == RD_RESP);

  assign M_ARADDR   = !rd_act ? '0 : (rd_sel ? S1_ARADDR : S0_ARADDR);
  assign M_ARVALID  = rd_addr_ph & (rd_sel ? S1_ARVALID : S0_ARVALID);
  assign M_RREADY   = rd_resp_ph & (rd_sel ? S1_RREADY : S0_RREADY);
  assign S0_ARREADY = rd_addr_ph & M_ARREADY & rd_grant_q[0];
  assign S1_ARREADY = rd_addr_ph & M_ARREADY & rd_grant_q[1];
  assign r_vld      = rd_resp_ph & M_RVALID;
  assign S0_RVALID  = r_vld & rd_grant_q[0];
  assign S1_RVALID  = r_vld & rd_grant_q[1];
  assign S0_RDATA   = (r_vld & rd_grant_q[0]) ? M_RDATA : '0;
  assign S1_RDATA   = (r_vld & rd_grant_q[1]) ? M_RDATA : '0;
  assign S0_RRESP   = (r_vld & rd_grant_q[0]) ? M_RRESP : RESP_OKAY;
  assign S1_RRESP   = (r_vld & rd_grant_q[1]) ? M_RRESP : RESP_OKAY;

  assign ar_hs = M_ARVALID & M_ARREADY;
  assign r_hs  = M_RVALID & M_RREADY;

  assign WR_GRANT = wr_grant_q;
  assign RD_GRANT = rd_grant_q;

  // Write FSM: AW and W may finish in either order; both must be done before the response.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_state_q <= WR_IDLE;
      wr_grant_q <= 2'b00;
      last_wr_q  <= 1'b1;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      unique case (wr_state_q)
        WR_IDLE: if (|wr_grant_d) begin
          wr_grant_q <= wr_grant_d;
          wr_state_q <= WR_ADDR;
        end
        WR_ADDR: if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          aw_done_q  <= 1'b0;
          w_done_q   <= 1'b0;
          wr_state_q <= WR_RESP;
        end else begin
          aw_done_q <= aw_done_q | aw_hs;
          w_done_q  <= w_done_q | w_hs;
        end
        WR_RESP: if (b_hs) begin
          last_wr_q  <= wr_grant_q[1];
          wr_grant_q <= 2'b00;
          wr_state_q <= WR_IDLE;
        end
        default: begin
          wr_grant_q <= 2'b00;
          wr_state_q <= WR_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_state_q <= RD_IDLE;
      rd_grant_q <= 2'b00;
      last_rd_q  <= 1'b1;
    end else begin
      unique case (rd_state_q)
        RD_IDLE: if (|rd_grant_d) begin
          rd_grant_q <= rd_grant_d;
          rd_state_q <= RD_ADDR;
        end
        RD_ADDR: if (ar_hs) rd_state_q <= RD_RESP;
        RD_RESP: if (r_hs) begin
          last_rd_q  <= rd_grant_q[1];
          rd_grant_q <= 2'b00;
          rd_state_q <= RD_IDLE;
        end
        default: begin
          rd_grant_q <= 2'b00;
          rd_state_q <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_4_lite_arbiter_2to1.sv
// Bench for the 2:1 AXI4-Lite arbiter: a simple register-block slave model, directed
// scenarios and randomized two-port traffic compared against a scoreboard memory.
module tb_axi_4_lite_arbiter_2to1;
  import axi_lite_arb_pkg::*;

  localparam int TMO = 300;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  logic [31:0] s_awaddr [2], s_wdata [2], s_araddr [2];
  logic [3:0]  s_wstrb [2];
  logic [1:0]  s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  wire  [1:0]  s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  wire  [1:0]  s_bresp [2], s_rresp [2];
  wire  [31:0] s_rdata [2];

  wire  [31:0] m_awaddr, m_wdata, m_araddr;
  wire  [3:0]  m_wstrb;
  wire         m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        m_awready, m_wready, m_arready;
  wire  [1:0]  wr_grant, rd_grant;

  // Slave model: single-entry AW/W capture, B one cycle after both, R one cycle after AR.
  logic        aw_have, w_have, sl_bvalid, sl_rvalid;
  logic [31:0] sl_awaddr, sl_wdata, sl_rdata;
  logic [3:0]  sl_wstrb;
  logic [1:0]  sl_bresp, sl_rresp;
  logic [31:0] mem [64];

  assign m_awready = !aw_have && !sl_bvalid;
  assign m_wready  = !w_have && !sl_bvalid;
  assign m_arready = !sl_rvalid;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      aw_have <= 1'b0; w_have <= 1'b0; sl_bvalid <= 1'b0; sl_rvalid <= 1'b0;
      sl_awaddr <= '0; sl_wdata <= '0; sl_wstrb <= '0; sl_bresp <= '0;
      sl_rdata <= '0; sl_rresp <= '0;
      for (int i = 0; i < 64; i++) mem[i] <= '0;
    end else begin
      if (m_awvalid && m_awready) begin aw_have <= 1'b1; sl_awaddr <= m_awaddr; end
      if (m_wvalid && m_wready) begin w_have <= 1'b1; sl_wdata <= m_wdata; sl_wstrb <= m_wstrb; end
      if (aw_have && w_have) begin
        aw_have <= 1'b0; w_have <= 1'b0; sl_bvalid <= 1'b1;
        if (sl_awaddr[1:0] != 2'b00) sl_bresp <= RESP_SLVERR;
        else begin
          sl_bresp <= RESP_OKAY;
          for (int b = 0; b < 4; b++)
            if (sl_wstrb[b]) mem[sl_awaddr[7:2]][8*b +: 8] <= sl_wdata[8*b +: 8];
        end
      end
      if (sl_bvalid && m_bready) sl_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        sl_rvalid <= 1'b1; sl_rdata <= mem[m_araddr[7:2]]; sl_rresp <= RESP_OKAY;
      end else if (sl_rvalid && m_rready) sl_rvalid <= 1'b0;
    end
  end

  axi_4_lite_arbiter_2to1 #(.ADDRESS(32), .DATA_WIDTH(32)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .S0_AWADDR(s_awaddr[0]), .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]),
    .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WVALID(s_wvalid[0]), .S0_WREADY(s_wready[0]),
    .S0_BRESP(s_bresp[0]), .S0_BVALID(s_bvalid[0]), .S0_BREADY(s_bready[0]),
    .S0_ARADDR(s_araddr[0]), .S0_ARVALID(s_arvalid[0]), .S0_ARREADY(s_arready[0]),
    .S0_RDATA(s_rdata[0]), .S0_RRESP(s_rresp[0]), .S0_RVALID(s_rvalid[0]), .S0_RREADY(s_rready[0]),
    .S1_AWADDR(s_awaddr[1]), .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]),
    .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WVALID(s_wvalid[1]), .S1_WREADY(s_wready[1]),
    .S1_BRESP(s_bresp[1]), .S1_BVALID(s_bvalid[1]), .S1_BREADY(s_bready[1]),
    .S1_ARADDR(s_araddr[1]), .S1_ARVALID(s_arvalid[1]), .S1_ARREADY(s_arready[1]),
    .S1_RDATA(s_rdata[1]), .S1_RRESP(s_rresp[1]), .S1_RVALID(s_rvalid[1]), .S1_RREADY(s_rready[1]),
    .M_AWADDR(m_awaddr), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
    .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
    .M_BRESP(sl_bresp), .M_BVALID(sl_bvalid), .M_BREADY(m_bready),
    .M_ARADDR(m_araddr), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
    .M_RDATA(sl_rdata), .M_RRESP(sl_rresp), .M_RVALID(sl_rvalid), .M_RREADY(m_rready),
    .WR_GRANT(wr_grant), .RD_GRANT(rd_grant)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: no handshake within %0d cycles", tag, TMO);
  endtask

  // Round-robin reference: a lone requester wins, a tie goes to the port not served last.
  function automatic logic [1:0] rr_ref(input logic [1:0] req, input logic last);
    if (req == 2'b11) return last ? 2'b01 : 2'b10;
    return req;
  endfunction

  logic       last_wr_ref, last_rd_ref, wr_pend, rd_pend, saw_both;
  logic [1:0] wr_exp, rd_exp, prev_wr_grant;
  int         wr_order [$];
  int         awv_cycles;

  always @(negedge CLK) begin
    if (!RESET_N) begin
      last_wr_ref = 1'b1; last_rd_ref = 1'b1;
      wr_pend = 1'b0; rd_pend = 1'b0; prev_wr_grant = 2'b00;
    end else begin
      logic leak;
      leak = 1'b0;
      for (int x = 0; x < 2; x++) begin
        if (!wr_grant[x] && (s_awready[x] || s_wready[x] || s_bvalid[x])) leak = 1'b1;
        if (!rd_grant[x] && (s_arready[x] || s_rvalid[x])) leak = 1'b1;
      end
      chk("no_leak_to_ungranted", leak, 1'b0);
      if (wr_pend) chk("wr_grant_pred", wr_grant, wr_exp);
      if (rd_pend) chk("rd_grant_pred", rd_grant, rd_exp);
      if (sl_bvalid && m_bready) last_wr_ref = wr_grant[1];
      if (sl_rvalid && m_rready) last_rd_ref = rd_grant[1];
      wr_pend = (wr_grant == 2'b00);
      rd_pend = (rd_grant == 2'b00);
      wr_exp  = rr_ref(s_awvalid, last_wr_ref);
      rd_exp  = rr_ref(s_arvalid, last_rd_ref);
      if (wr_grant != 2'b00 && prev_wr_grant == 2'b00) wr_order.push_back(int'(wr_grant[1]));
      prev_wr_grant = wr_grant;
      if (wr_grant == 2'b01 && rd_grant == 2'b10) saw_both = 1'b1;
      if (m_awvalid) awv_cycles++;
    end
  end

  task automatic do_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int wdly, input int bdly,
                          output logic [1:0] resp);
    int cyc;
    logic aw_ok, w_ok, aw_hs, w_hs, b_hs;
    aw_ok = 1'b0; w_ok = 1'b0; cyc = 0; resp = 2'bxx;
    @(posedge CLK); #1;
    s_awaddr[p] = addr; s_wdata[p] = data; s_wstrb[p] = strb;
    s_awvalid[p] = 1'b1; s_wvalid[p] = (wdly == 0);
    while (!(aw_ok && w_ok)) begin
      @(negedge CLK);
      aw_hs = s_awvalid[p] && s_awready[p];
      w_hs  = s_wvalid[p] && s_wready[p];
      @(posedge CLK); #1;
      if (aw_hs) begin aw_ok = 1'b1; s_awvalid[p] = 1'b0; end
      if (w_hs) begin w_ok = 1'b1; s_wvalid[p] = 1'b0; end
      cyc++;
      if (!w_ok && cyc >= wdly) s_wvalid[p] = 1'b1;
      if (cyc > TMO) begin
        tmo("write_addr"); s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0; return;
      end
    end
    cyc = 0;
    s_bready[p] = (bdly == 0);
    forever begin
      @(negedge CLK);
      b_hs = s_bvalid[p] && s_bready[p];
      if (b_hs) resp = s_bresp[p];
      @(posedge CLK); #1;
      if (b_hs) begin s_bready[p] = 1'b0; break; end
      cyc++;
      if (cyc >= bdly) s_bready[p] = 1'b1;
      if (cyc > TMO) begin tmo("write_resp"); s_bready[p] = 1'b0; break; end
    end
  endtask

  task automatic do_read(input int p, input logic [31:0] addr, input int rdly,
                         output logic [31:0] data, output logic [1:0] resp);
    int cyc;
    logic hs;
    cyc = 0; data = 'x; resp = 2'bxx;
    @(posedge CLK); #1;
    s_araddr[p] = addr; s_arvalid[p] = 1'b1;
    forever begin
      @(negedge CLK);
      hs = s_arready[p];
      @(posedge CLK); #1;
      if (hs) begin s_arvalid[p] = 1'b0; break; end
      cyc++;
      if (cyc > TMO) begin tmo("read_addr"); s_arvalid[p] = 1'b0; return; end
    end
    cyc = 0;
    s_rready[p] = (rdly == 0);
    forever begin
      @(negedge CLK);
      hs = s_rvalid[p] && s_rready[p];
      if (hs) begin data = s_rdata[p]; resp = s_rresp[p]; end
      @(posedge CLK); #1;
      if (hs) begin s_rready[p] = 1'b0; break; end
      cyc++;
      if (cyc >= rdly) s_rready[p] = 1'b1;
      if (cyc > TMO) begin tmo("read_data"); s_rready[p] = 1'b0; break; end
    end
  endtask

  logic [31:0] ref_mem [2][16];

  task automatic rnd_port(input int p);
    logic [31:0] base, addr, data, rd;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          idx;
    logic        unal;
    base = (p == 0) ? 32'h40 : 32'h80;
    for (int n = 0; n < 12; n++) begin
      idx  = $urandom_range(0, 15);
      data = $urandom;
      strb = 4'($urandom_range(1, 15));
      unal = ($urandom_range(0, 5) == 0);
      addr = base + 32'(idx * 4) + (unal ? 32'd2 : 32'd0);
      do_write(p, addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), resp);
      chk("rnd_bresp", resp, unal ? RESP_SLVERR : RESP_OKAY);
      if (!unal)
        for (int b = 0; b < 4; b++)
          if (strb[b]) ref_mem[p][idx][8*b +: 8] = data[8*b +: 8];
      idx = $urandom_range(0, 15);
      do_read(p, base + 32'(idx * 4), $urandom_range(0, 3), rd, resp);
      chk("rnd_rdata", rd, ref_mem[p][idx]);
      chk("rnd_rresp", resp, RESP_OKAY);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  resp, resp_b;
    logic [31:0] rd, rd_b;
    int          n, awv0, cyc;
    for (int p = 0; p < 2; p++) begin
      s_awaddr[p] = '0; s_wdata[p] = '0; s_wstrb[p] = '0; s_araddr[p] = '0;
      for (int i = 0; i < 16; i++) ref_mem[p][i] = '0;
    end
    s_awvalid = '0; s_wvalid = '0; s_bready = '0; s_arvalid = '0; s_rready = '0;
    saw_both = 1'b0; awv_cycles = 0;
    RESET_N = 1'b0;
    #23;
    chk("rst_m_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 5'b0);
    chk("rst_s_handshakes", {s_awready, s_wready, s_bvalid, s_arready, s_rvalid}, 10'b0);
    chk("rst_m_payload", {m_awaddr, m_wdata}, 64'h0);
    chk("rst_m_araddr_strb", {m_araddr, m_wstrb}, 36'h0);
    chk("rst_s_rdata", {s_rdata[0], s_rdata[1]}, 64'h0);
    chk("rst_grants", {wr_grant, rd_grant}, 4'b0);
    @(posedge CLK); #1 RESET_N = 1'b1;

    // Reset asserted while port 0 is in the address phase.
    @(posedge CLK); #1;
    s_awaddr[0] = 32'h20; s_awvalid[0] = 1'b1;
    @(negedge CLK);
    chk("idle_no_forward", m_awvalid, 1'b0);
    @(negedge CLK);
    chk("midwr_m_awvalid", m_awvalid, 1'b1);
    chk("midwr_grant", wr_grant, 2'b01);
    #1 RESET_N = 1'b0;
    #1;
    chk("async_rst_m_awvalid", m_awvalid, 1'b0);
    chk("async_rst_s0_awready", s_awready[0], 1'b0);
    chk("async_rst_wr_grant", wr_grant, 2'b00);
    s_awvalid[0] = 1'b0;
    @(posedge CLK); @(posedge CLK); #1 RESET_N = 1'b1;

    // Both ports writing back-to-back: first tie after reset goes to port 0, then alternate.
    wr_order.delete();
    fork
      begin
        do_write(0, 32'h10, 32'h1111_0000, 4'hF, 0, 0, resp);
        do_write(0, 32'h18, 32'h3333_0000, 4'hF, 0, 0, resp);
      end
      begin
        do_write(1, 32'h14, 32'h2222_0000, 4'hF, 0, 0, resp_b);
        do_write(1, 32'h1C, 32'h4444_0000, 4'hF, 0, 0, resp_b);
      end
    join
    chk("rr_order_len", wr_order.size(), 4);
    for (int i = 0; i < 4 && i < wr_order.size(); i++)
      chk($sformatf("rr_order_%0d", i), wr_order[i], i % 2);

    // Port 0 writes 0xDEADBEEF to 0x04; forwarding starts the cycle after the request.
    fork
      do_write(0, 32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, resp);
      begin
        @(posedge CLK);
        @(negedge CLK);
        chk("n_no_grant", wr_grant, 2'b00);
        @(negedge CLK);
        chk("n1_grant", wr_grant, 2'b01);
        chk("n1_m_awaddr", m_awaddr, 32'h04);
        chk("n1_m_wdata", m_wdata, 32'hDEAD_BEEF);
      end
    join
    chk("s0_bresp_okay", resp, RESP_OKAY);
    do_read(1, 32'h04, 0, rd, resp);
    chk("p1_read_0x04", rd, 32'hDEAD_BEEF);
    chk("p1_read_resp", resp, RESP_OKAY);

    // Concurrent write (port 0) and read (port 1) hold grants on different ports.
    saw_both = 1'b0;
    fork
      do_write(0, 32'h08, 32'h1234_5678, 4'hF, 1, 2, resp);
      do_read(1, 32'h08, 2, rd, resp_b);
    join
    chk("both_grants_seen", saw_both, 1'b1);
    chk("concurrent_bresp", resp, RESP_OKAY);

    // Port 1 unaligned write with W three cycles late: AW accepted once, SLVERR returned.
    awv0 = awv_cycles;
    do_write(1, 32'h06, 32'hCAFE_F00D, 4'hF, 3, 0, resp);
    chk("aw_single_valid_cycle", awv_cycles - awv0, 1);
    chk("s1_bresp_slverr", resp, RESP_SLVERR);

    // Port 0 stalls RREADY for 5 cycles while port 1 has a read pending.
    fork
      do_read(0, 32'h04, 5, rd, resp);
      begin
        @(posedge CLK); @(posedge CLK);
        do_read(1, 32'h08, 0, rd_b, resp_b);
      end
      begin
        n = 0; cyc = 0;
        @(posedge CLK);
        forever begin
          @(negedge CLK);
          if (rd_grant == 2'b01 && s_rvalid[0]) n++;
          if (s_rvalid[0] && s_rready[0]) break;
          cyc++;
          if (cyc > TMO) begin tmo("rready_stall"); break; end
        end
        chk("rd_resp_hold_cycles", n, 6);
        @(negedge CLK);
        chk("rd_idle_after_r", rd_grant, 2'b00);
        @(negedge CLK);
        chk("rd_grant_p1", rd_grant, 2'b10);
      end
    join
    chk("stall_rdata_p0", rd, 32'hDEAD_BEEF);
    chk("pending_rdata_p1", rd_b, 32'h1234_5678);

    // Randomized traffic on both ports against the scoreboard memory.
    fork
      rnd_port(0);
      rnd_port(1);
    join

    repeat (3) @(posedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
